// File: rtl/serial_adder_n_if.sv
// Operand/result bundle between a controller and serial_adder_n.
// The controller drives the request side; the adder returns status and result.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Controller side: issues operations, observes status and result.
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  // Adder side: accepts operations, drives status and result.
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock through a
// single registered carry, LSB digit first. Result, carry-out and signed
// overflow are published together on the last digit and held until the next
// operation completes.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_adder_n_if.slave bus
);

  // Guarded so a bad DIGIT reports the $error below instead of a divide fault.
  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = $clog2(N + 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder_n: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder_n: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Operand shift registers: the low DIGIT bits are the digit in flight.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Result fills from the MSB end so the LSB digit lands at bit 0 at the end.
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             dcarry_msb;
  logic             last;
  logic             accept;

  assign last   = (cnt == CW'(1));
  assign accept = (state == IDLE) && bus.start;

  // Digit ripple: add the low digit of A and B plus the registered carry, and
  // keep the carry entering the digit's top bit for the overflow flag.
  always_comb begin
    logic c;
    // NOTE: every combinational output gets a value before any branch or loop,
    // so no path can leave it unassigned and infer a latch.
    c          = carry;
    dsum       = '0;
    dcarry_msb = carry;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) dcarry_msb = c;
      dsum[i] = a_sr[i] ^ b_sr[i] ^ c;
      c       = (a_sr[i] & b_sr[i]) | (c & (a_sr[i] ^ b_sr[i]));
    end
    dcarry = c;
  end

  // Result shift: drop the oldest digit position, insert the new digit at the top.
  always_comb begin
    res_nxt = (res_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE leaves on start, RUN returns after the last digit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.busy = (state == RUN);
  end

  // Datapath: capture operands on accept, then shift one digit per RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= bus.a;
      // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
      b_sr   <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.sub | bus.cin;
      res_sr <= '0;
      cnt    <= CW'(N);
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_nxt;
      carry  <= dcarry;
      cnt    <= cnt - CW'(1);
    end
  end

  // Result registers: load only on the final digit so they hold while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= (state == RUN) && last;
      if ((state == RUN) && last) begin
        bus.sum  <= res_nxt;
        bus.cout <= dcarry;
        bus.ovf  <= dcarry_msb ^ dcarry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n in three shapes: 8/1 (eight digits), 4/2 (two
// digits, exhaustive) and 8/8 (single digit, random). Expected results come
// from integer arithmetic on the operands, not from the adder's structure.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(8)) if8  ();
  serial_adder_n_if #(.WIDTH(4)) if4  ();
  serial_adder_n_if #(.WIDTH(8)) if88 ();

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_n #(.WIDTH(4), .DIGIT(2)) dut4  (.clk(clk), .rst(rst), .bus(if4));
  serial_adder_n #(.WIDTH(8), .DIGIT(8)) dut88 (.clk(clk), .rst(rst), .bus(if88));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } outs_t;

  // Instance selector: 0 = 8/1, 1 = 4/2, 2 = 8/8.
  function automatic int n_of(int w);
    return (w == 0) ? 8 : (w == 1) ? 2 : 1;
  endfunction

  function automatic int width_of(int w);
    return (w == 1) ? 4 : 8;
  endfunction

  function automatic outs_t get_outs(int w);
    outs_t o;
    case (w)
      0:       o = {if8.busy,  if8.done,  if8.sum,         if8.cout,  if8.ovf};
      1:       o = {if4.busy,  if4.done,  4'b0, if4.sum,   if4.cout,  if4.ovf};
      default: o = {if88.busy, if88.done, if88.sum,        if88.cout, if88.ovf};
    endcase
    return o;
  endfunction

  task automatic drive(int w, logic st, logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    case (w)
      0: begin if8.start = st;  if8.a = a;       if8.b = b;       if8.cin = cin;  if8.sub = sub;  end
      1: begin if4.start = st;  if4.a = a[3:0];  if4.b = b[3:0];  if4.cin = cin;  if4.sub = sub;  end
      default: begin if88.start = st; if88.a = a; if88.b = b;     if88.cin = cin; if88.sub = sub; end
    endcase
  endtask

  // Reference: unsigned sum with carry, and signed-range overflow of the true
  // signed result (a+b+cin or a-b) for the instance's width.
  function automatic void model(int w, logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                                output logic [7:0] s, output logic co, output logic ov);
    int wd   = width_of(w);
    int mask = (1 << wd) - 1;
    int ua   = int'(a) & mask;
    int ub   = int'(b) & mask;
    int tot, sa, sb, r;
    tot = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub + int'(cin));
    s   = 8'(tot & mask);
    co  = ((tot >> wd) & 1) != 0;
    sa  = (ua >= (1 << (wd - 1))) ? ua - (1 << wd) : ua;
    sb  = (ub >= (1 << (wd - 1))) ? ub - (1 << wd) : ub;
    r   = sub ? (sa - sb) : (sa + sb + int'(cin));
    ov  = (r > (1 << (wd - 1)) - 1) || (r < -(1 << (wd - 1)));
  endfunction

  // Issue one operation from a falling edge; returns at the falling edge where
  // done is seen (lat = RUN edges after accept) or after a bounded wait (lat=-1).
  // With noise set, start is re-asserted with junk operands mid-run.
  task automatic run_op(int w, logic [7:0] a, logic [7:0] b, logic cin, logic sub, bit noise,
                        output outs_t res, output int lat, output bit held_ok, output bit overlap);
    outs_t prev, o;
    int n = n_of(w);
    prev    = get_outs(w);
    held_ok = 1'b1;
    overlap = 1'b0;
    lat     = -1;
    o       = prev;
    drive(w, 1'b1, a, b, cin, sub);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int k = 0; k <= n + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (noise && k >= 2 && k <= 4) drive(w, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      if (noise && k == 5)           drive(w, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      o = get_outs(w);
      if (o.busy && o.done) overlap = 1'b1;
      if (o.done) begin
        lat = k;
        break;
      end
      if (o.sum !== prev.sum || o.cout !== prev.cout || o.ovf !== prev.ovf) held_ok = 1'b0;
    end
    res = o;
  endtask

  task automatic test_reset();
    outs_t o;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      o = get_outs(w);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                 w, o.busy, o.done, o.sum, o.cout, o.ovf);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    outs_t o;
    int lat;
    bit held, ovl;
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_ff_01: got sum=%h cout=%b ovf=%b, want 00 1 0", o.sum, o.cout, o.ovf);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL add_latency: got %0d edges, want 8", lat);
    end
    checks++;
    if (ovl !== 1'b0) begin
      errors++;
      $display("FAIL add_busy_done_overlap: got overlap=%b, want 0", ovl);
    end
    @(negedge clk);
    o = get_outs(0);
    checks++;
    if ({o.done, o.busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", o.done, o.busy);
    end
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_7f_01: got sum=%h cout=%b ovf=%b, want 80 0 1", o.sum, o.cout, o.ovf);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL add_hold: got held=%b, want 1", held);
    end
  endtask

  task automatic test_sub();
    outs_t o;
    int lat;
    bit held, ovl;
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_05_07: got sum=%h cout=%b ovf=%b, want fe 0 0", o.sum, o.cout, o.ovf);
    end
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b, want 7f 1 1", o.sum, o.cout, o.ovf);
    end
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_cin_ignored: got sum=%h cout=%b ovf=%b, want fe 0 0", o.sum, o.cout, o.ovf);
    end
  endtask

  task automatic test_handshake();
    outs_t o;
    int lat;
    bit held, ovl;
    run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'h46, 1'b0, 1'b0} || lat !== 8) begin
      errors++;
      $display("FAIL start_ignored_busy: got sum=%h cout=%b ovf=%b lat=%0d, want 46 0 0 lat=8",
               o.sum, o.cout, o.ovf, lat);
    end
    // Issued in the done cycle of the previous operation.
    run_op(0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'h80, 1'b0, 1'b1} || lat !== 8) begin
      errors++;
      $display("FAIL back_to_back: got sum=%h cout=%b ovf=%b lat=%0d, want 80 0 1 lat=8",
               o.sum, o.cout, o.ovf, lat);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_hold: got held=%b, want 1 (sum stays 46 while busy)", held);
    end
  endtask

  task automatic test_reset_mid();
    outs_t o;
    int lat;
    bit held, ovl, saw_done;
    drive(0, 1'b1, 8'h55, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 o = get_outs(0);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               o.busy, o.done, o.sum, o.cout, o.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      o = get_outs(0);
      if (o.done || o.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got activity=%b after abort, want 0", saw_done);
    end
    run_op(0, 8'h55, 8'h22, 1'b0, 1'b0, 1'b0, o, lat, held, ovl);
    checks++;
    if ({o.sum, o.cout, o.ovf} !== {8'h77, 1'b0, 1'b0} || lat !== 8) begin
      errors++;
      $display("FAIL reset_mid_restart: got sum=%h cout=%b ovf=%b lat=%0d, want 77 0 0 lat=8",
               o.sum, o.cout, o.ovf, lat);
    end
  endtask

  // Randomised or exhaustive sweep of one instance against the reference model.
  task automatic test_sweep(int w, bit exhaustive, int count);
    outs_t o;
    int lat, total;
    bit held, ovl;
    logic [7:0] a, b, es;
    logic cin, sub, ec, ev;
    total = exhaustive ? 16 * 16 * 3 : count;
    for (int i = 0; i < total; i++) begin
      if (exhaustive) begin
        a   = 8'(i % 16);
        b   = 8'((i / 16) % 16);
        sub = (i / 256) == 2;
        cin = sub ? 1'($urandom) : 1'((i / 256) == 1);
      end else begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      model(w, a, b, cin, sub, es, ec, ev);
      run_op(w, a, b, cin, sub, (w == 0) ? 1'($urandom) : 1'b0, o, lat, held, ovl);
      checks++;
      if ({o.sum, o.cout, o.ovf} !== {es, ec, ev}) begin
        errors++;
        $display("FAIL sweep%0d_result a=%h b=%h cin=%b sub=%b: got %h %b %b, want %h %b %b",
                 w, a, b, cin, sub, o.sum, o.cout, o.ovf, es, ec, ev);
      end
      checks++;
      if (lat !== n_of(w)) begin
        errors++;
        $display("FAIL sweep%0d_latency: got %0d, want %0d", w, lat, n_of(w));
      end
      checks++;
      if (held !== 1'b1 || ovl !== 1'b0) begin
        errors++;
        $display("FAIL sweep%0d_hold: got held=%b overlap=%b, want 1 0", w, held, ovl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_handshake();
    test_reset_mid();
    test_sweep(0, 1'b0, 40);
    test_sweep(1, 1'b1, 0);
    test_sweep(2, 1'b0, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
